// File: rtl/xadc_drp_ctrl.sv
// XADC DRP sequencer: writes three config registers after reset, reads a sample on every eoc, and serves host accesses in idle slots.
// Define XADC_DRP_TIMEOUT_EN to abort DRP accesses that get no drdy within TIMEOUT_CYCLES and to raise err_o.
module xadc_drp_ctrl #(
  parameter logic [15:0] CFG0           = 16'h0016,
  parameter logic [15:0] CFG1           = 16'h2000,
  parameter logic [15:0] CFG2           = 16'h0400,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_78MHz_i,
  input  logic        reset_i,
  output logic [6:0]  drp_daddr_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,
  input  logic        xadc_eoc_i,
  input  logic [4:0]  xadc_channel_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [6:0]  host_addr_i,
  input  logic [15:0] host_wdata_i,
  output logic        host_ack_o,
  output logic [15:0] host_rdata_o,
  output logic [11:0] data_o,
  output logic [4:0]  channel_o,
  output logic        ready_o,
  output logic        cfg_done_o,
  output logic        overrun_o,
  output logic        err_o
);

  // state | meaning: CFG_* config write idx | IDLE arbitrate | SMP_* sample read | HOST_* host access
  typedef enum logic [2:0] {
    CFG_ISSUE, CFG_WAIT, IDLE, SMP_ISSUE, SMP_WAIT, HOST_ISSUE, HOST_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        pending;
  logic [4:0]  eoc_ch;
  logic        in_wait, timeout, done, pend_clr;
  logic [15:0] cfg_val;

  assign in_wait  = (state == CFG_WAIT) || (state == SMP_WAIT) || (state == HOST_WAIT);
  assign done     = in_wait && (drp_drdy_i || timeout);
  assign pend_clr = (state == IDLE) && (state_nxt == SMP_ISSUE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      CFG_ISSUE: if (drp_den_o) state_nxt = CFG_WAIT;
      CFG_WAIT: begin
        if (done) begin
          if (idx == 2'd2) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = CFG_ISSUE;
            idx_nxt   = idx + 2'd1;
          end
        end
      end
      // an eoc arriving this cycle blocks the host so the sample wins next cycle
      IDLE: begin
        if (pending)
          state_nxt = SMP_ISSUE;
        else if (host_req_i && cfg_done_o && !host_ack_o && !xadc_eoc_i)
          state_nxt = HOST_ISSUE;
      end
      SMP_ISSUE:  if (drp_den_o) state_nxt = SMP_WAIT;
      SMP_WAIT:   if (done) state_nxt = IDLE;
      HOST_ISSUE: if (drp_den_o) state_nxt = HOST_WAIT;
      HOST_WAIT:  if (done) state_nxt = IDLE;
      default:    state_nxt = CFG_ISSUE;
    endcase
  end

  always_comb begin
    cfg_val = CFG2;
    case (idx_nxt)
      2'd0:    cfg_val = CFG0;
      2'd1:    cfg_val = CFG1;
      default: cfg_val = CFG2;
    endcase
  end

  always_ff @(posedge clk_78MHz_i) begin
    if (reset_i) begin
      state        <= CFG_ISSUE;
      idx          <= 2'd0;
      pending      <= 1'b0;
      eoc_ch       <= 5'd0;
      drp_daddr_o  <= 7'd0;
      drp_den_o    <= 1'b0;
      drp_dwe_o    <= 1'b0;
      drp_di_o     <= 16'd0;
      host_ack_o   <= 1'b0;
      host_rdata_o <= 16'd0;
      data_o       <= 12'd0;
      channel_o    <= 5'd0;
      ready_o      <= 1'b0;
      cfg_done_o   <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      drp_den_o  <= 1'b0;
      ready_o    <= 1'b0;
      host_ack_o <= 1'b0;

      // den is high for the cycle spent in an ISSUE state
      if (state_nxt == CFG_ISSUE) begin
        drp_den_o   <= 1'b1;
        drp_daddr_o <= {5'b10000, idx_nxt};
        drp_dwe_o   <= 1'b1;
        drp_di_o    <= cfg_val;
      end
      if (state_nxt == SMP_ISSUE) begin
        drp_den_o   <= 1'b1;
        drp_daddr_o <= {2'b00, eoc_ch};
        drp_dwe_o   <= 1'b0;
        drp_di_o    <= 16'd0;
      end
      if (state_nxt == HOST_ISSUE) begin
        drp_den_o   <= 1'b1;
        drp_daddr_o <= host_addr_i;
        drp_dwe_o   <= host_we_i;
        drp_di_o    <= host_wdata_i;
      end

      if (state == SMP_WAIT && drp_drdy_i) begin
        ready_o   <= 1'b1;
        data_o    <= drp_do_i[15:4];
        channel_o <= drp_daddr_o[4:0];
      end
      if (state == HOST_WAIT && done) begin
        host_ack_o   <= 1'b1;
        host_rdata_o <= !drp_drdy_i ? 16'hFFFF : (drp_dwe_o ? 16'h0000 : drp_do_i);
      end
      if (state == CFG_WAIT && done && idx == 2'd2)
        cfg_done_o <= 1'b1;

      if (xadc_eoc_i) begin
        pending <= 1'b1;
        eoc_ch  <= xadc_channel_i;
        if (pending && !pend_clr)
          overrun_o <= 1'b1;
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 2);

  logic [TW-1:0] tmr;

  // loaded while den is high so that it reaches zero TIMEOUT_CYCLES-1 cycles after den
  always_ff @(posedge clk_78MHz_i) begin
    if (reset_i) begin
      tmr   <= '0;
      err_o <= 1'b0;
    end else begin
      if (drp_den_o)
        tmr <= TMR_LOAD;
      else if (tmr != '0)
        tmr <= tmr - TW'(1);
      if (timeout)
        err_o <= 1'b1;
    end
  end

  assign timeout = in_wait && !drp_drdy_i && (tmr == '0);
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_drp_ctrl.sv
// Scoreboard bench for xadc_drp_ctrl: a DRP model answers accesses, a monitor pops expected accesses, samples and host acks.
`timescale 1ns/1ps
module tb_xadc_drp_ctrl;
  localparam logic [15:0] CFG0 = 16'h0016;
  localparam logic [15:0] CFG1 = 16'h2000;
  localparam logic [15:0] CFG2 = 16'h0400;
  localparam int TMO = 64;

  logic        clk_78MHz_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [6:0]  drp_daddr_o;
  logic        drp_den_o, drp_dwe_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i = 16'h0;
  logic        drp_drdy_i = 1'b0;
  logic        xadc_eoc_i = 1'b0;
  logic [4:0]  xadc_channel_i = 5'd0;
  logic        host_req_i = 1'b0, host_we_i = 1'b0;
  logic [6:0]  host_addr_i = 7'd0;
  logic [15:0] host_wdata_i = 16'h0;
  logic        host_ack_o;
  logic [15:0] host_rdata_o;
  logic [11:0] data_o;
  logic [4:0]  channel_o;
  logic        ready_o, cfg_done_o, overrun_o, err_o;

  xadc_drp_ctrl #(.CFG0(CFG0), .CFG1(CFG1), .CFG2(CFG2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_78MHz_i(clk_78MHz_i), .reset_i(reset_i),
    .drp_daddr_o(drp_daddr_o), .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o),
    .drp_di_o(drp_di_o), .drp_do_i(drp_do_i), .drp_drdy_i(drp_drdy_i),
    .xadc_eoc_i(xadc_eoc_i), .xadc_channel_i(xadc_channel_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o),
    .data_o(data_o), .channel_o(channel_o), .ready_o(ready_o),
    .cfg_done_o(cfg_done_o), .overrun_o(overrun_o), .err_o(err_o)
  );

  always #5 clk_78MHz_i = ~clk_78MHz_i;

  int cyc = 0;
  always @(posedge clk_78MHz_i) cyc <= cyc + 1;

  typedef struct packed {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
  } acc_t;

  acc_t        exp_acc[$];
  logic [16:0] exp_smp[$];
  logic [15:0] exp_host[$];
  int checks = 0;
  int passes = 0;
  int last_ready_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] outs();
    return {1'b0, drp_daddr_o, drp_den_o, drp_dwe_o, drp_di_o, host_ack_o, host_rdata_o,
            data_o, channel_o, ready_o, cfg_done_o, overrun_o, err_o};
  endfunction

  task automatic exp_wr(input logic [6:0] a, input logic [15:0] d);
    exp_acc.push_back('{addr: a, we: 1'b1, di: d});
  endtask

  task automatic exp_rd(input logic [6:0] a);
    exp_acc.push_back('{addr: a, we: 1'b0, di: 16'h0});
  endtask

  // DRP model: one access at a time, drdy three cycles after den
  logic [15:0] mem [0:127];
  bit model_en = 1'b1;
  bit drop_smp = 1'b0;
  initial begin
    logic [6:0] a;
    logic w;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    mem[2] = 16'h7770; mem[3] = 16'h3330; mem[4] = 16'h4560;
    mem[5] = 16'h1230; mem[6] = 16'hABC0;
    forever begin
      @(negedge clk_78MHz_i);
      if (drp_den_o && model_en && !reset_i) begin
        a = drp_daddr_o;
        w = drp_dwe_o;
        if (w) mem[a] = drp_di_o;
        if (!(drop_smp && !w && a < 7'h20)) begin
          repeat (3) @(posedge clk_78MHz_i);
          #1;
          drp_drdy_i = 1'b1;
          drp_do_i   = w ? 16'h0 : mem[a];
          @(posedge clk_78MHz_i);
          #1;
          drp_drdy_i = 1'b0;
        end
      end
    end
  end

  acc_t mon_e;
  always @(negedge clk_78MHz_i) begin
    if (drp_den_o) begin
      if (exp_acc.size() == 0) chk("spurious_den", 64'(drp_den_o), 64'd0);
      else begin
        mon_e = exp_acc.pop_front();
        chk("drp_access", 64'({drp_daddr_o, drp_dwe_o, drp_dwe_o ? drp_di_o : 16'h0}),
            64'({mon_e.addr, mon_e.we, mon_e.we ? mon_e.di : 16'h0}));
      end
    end
    if (ready_o) begin
      last_ready_cyc = cyc;
      if (exp_smp.size() == 0) chk("spurious_ready", 64'(ready_o), 64'd0);
      else chk("sample", 64'({channel_o, data_o}), 64'(exp_smp.pop_front()));
    end
    if (host_ack_o) begin
      if (exp_host.size() == 0) chk("spurious_ack", 64'(host_ack_o), 64'd0);
      else chk("host_rdata", 64'(host_rdata_o), 64'(exp_host.pop_front()));
    end
  end

  task automatic wait_to(input int n);
    do @(negedge clk_78MHz_i); while (cyc < n);
  endtask

  task automatic go_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk_78MHz_i);
      #1;
    end
  endtask

  task automatic eoc_pulse(input logic [4:0] ch, output int e);
    @(posedge clk_78MHz_i);
    #1;
    xadc_eoc_i = 1'b1;
    xadc_channel_i = ch;
    e = cyc;
    @(posedge clk_78MHz_i);
    #1;
    xadc_eoc_i = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_78MHz_i);
      if (host_ack_o) break;
    end
    chk("host_ack_seen", 64'(host_ack_o), 64'd1);
    @(posedge clk_78MHz_i);
    #1;
    host_req_i = 1'b0;
  endtask

  task automatic host_xfer(input logic we, input logic [6:0] a, input logic [15:0] d);
    @(posedge clk_78MHz_i);
    #1;
    host_req_i = 1'b1; host_we_i = we; host_addr_i = a; host_wdata_i = d;
    wait_ack();
  endtask

  task automatic wait_cfg_done(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_78MHz_i);
      if (cfg_done_o) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_acc.size() + exp_smp.size() + exp_host.size() == 0) break;
      @(negedge clk_78MHz_i);
    end
    repeat (3) @(negedge clk_78MHz_i);
    chk("queues_drained", 64'(exp_acc.size() + exp_smp.size() + exp_host.size()), 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int rel, e, c;
    repeat (4) @(posedge clk_78MHz_i);
    @(negedge clk_78MHz_i);
    chk("reset_outputs", outs(), 64'd0);

    // config sequence after reset release
    exp_wr(7'h40, CFG0); exp_wr(7'h41, CFG1); exp_wr(7'h42, CFG2);
    @(posedge clk_78MHz_i);
    #1;
    reset_i = 1'b0;
    rel = cyc;
    wait_to(rel + 1);
    chk("first_cfg_den", 64'({drp_den_o, drp_daddr_o}), 64'({1'b1, 7'h40}));
    wait_cfg_done(c);
    chk("cfg_done_cycle", 64'(c), 64'(rel + 13));
    drain();

    // single sample read
    exp_rd(7'h06); exp_smp.push_back({5'd6, 12'hABC});
    eoc_pulse(5'd6, e);
    wait_to(e + 2);
    chk("smp_den_cycle", 64'({drp_den_o, drp_daddr_o}), 64'({1'b1, 7'h06}));
    drain();
    chk("ready_latency", 64'(last_ready_cyc), 64'(e + 6));
    chk("data_hold", 64'({channel_o, data_o}), 64'({5'd6, 12'hABC}));

    // host read and eoc in the same idle cycle: sample first
    exp_rd(7'h05); exp_rd(7'h41);
    exp_smp.push_back({5'd5, 12'h123}); exp_host.push_back(CFG1);
    @(posedge clk_78MHz_i);
    #1;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 7'h41;
    xadc_eoc_i = 1'b1; xadc_channel_i = 5'd5;
    @(posedge clk_78MHz_i);
    #1;
    xadc_eoc_i = 1'b0;
    wait_ack();
    drain();

    // two eocs during an outstanding read: overrun, newest channel wins
    exp_rd(7'h02); exp_rd(7'h04);
    exp_smp.push_back({5'd2, 12'h777}); exp_smp.push_back({5'd4, 12'h456});
    eoc_pulse(5'd2, e);
    go_cycle(e + 3);
    xadc_eoc_i = 1'b1; xadc_channel_i = 5'd3;
    @(negedge clk_78MHz_i);
    chk("no_overrun_single", 64'(overrun_o), 64'd0);
    go_cycle(e + 4);
    xadc_channel_i = 5'd4;
    go_cycle(e + 5);
    xadc_eoc_i = 1'b0;
    drain();
    chk("overrun_set", 64'(overrun_o), 64'd1);

    // host write then read back
    exp_wr(7'h50, 16'h1234); exp_host.push_back(16'h0000);
    host_xfer(1'b1, 7'h50, 16'h1234);
    exp_rd(7'h50); exp_host.push_back(16'h1234);
    host_xfer(1'b0, 7'h50, 16'h0);
    drain();

`ifdef XADC_DRP_TIMEOUT_EN
    drop_smp = 1'b1;
    exp_rd(7'h06);
    eoc_pulse(5'd6, e);
    wait_to(e + 2 + TMO - 1);
    chk("err_before_timeout", 64'(err_o), 64'd0);
    wait_to(e + 2 + TMO);
    chk("err_at_timeout", 64'(err_o), 64'd1);
    drop_smp = 1'b0;
    exp_rd(7'h41); exp_host.push_back(CFG1);
    host_xfer(1'b0, 7'h41, 16'h0);
    drain();
`else
    chk("err_tied_low", 64'(err_o), 64'd0);
`endif

    // reset during SMP_WAIT with late drdy
    model_en = 1'b0;
    exp_rd(7'h06);
    eoc_pulse(5'd6, e);
    wait_to(e + 2);
    chk("rst_smp_den", 64'({drp_den_o, drp_daddr_o}), 64'({1'b1, 7'h06}));
    go_cycle(e + 3);
    reset_i = 1'b1;
    go_cycle(e + 4);
    drp_drdy_i = 1'b1; drp_do_i = 16'hFFF0;
    go_cycle(e + 5);
    drp_drdy_i = 1'b0;
    wait_to(e + 5);
    chk("reset_mid_access", outs(), 64'd0);
    exp_wr(7'h40, CFG0); exp_wr(7'h41, CFG1); exp_wr(7'h42, CFG2);
    go_cycle(e + 6);
    reset_i = 1'b0;
    rel = cyc;
    drp_drdy_i = 1'b1;
    go_cycle(rel + 1);
    drp_drdy_i = 1'b0;
    model_en = 1'b1;
    wait_to(rel + 1);
    chk("restart_cfg_den", 64'({drp_den_o, drp_daddr_o}), 64'({1'b1, 7'h40}));
    wait_cfg_done(c);
    chk("restart_cfg_done", 64'(c), 64'(rel + 13));
    chk("flags_cleared", 64'({overrun_o, err_o}), 64'd0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/xadc_drp_ctrl.md
# xadc_drp_ctrl

Sequencer and arbiter for the XADC dynamic reconfiguration port (DRP). After reset it writes three configuration registers. It then reads the conversion result of every end-of-conversion from the channel's status register, and emits a 12-bit sample with a one-cycle valid. In idle DRP slots it serves a single host register read/write port. It sits between the XADC primitive and the FIFO/FIR sample path, replacing direct `eoc`→`den` wiring.

## Interface
Parameters:
- `CFG0` — default 16'h0016 — value written to DRP 0x40 (config reg 0)
- `CFG1` — default 16'h2000 — value written to DRP 0x41 (config reg 1)
- `CFG2` — default 16'h0400 — value written to DRP 0x42 (config reg 2)
- `TIMEOUT_CYCLES` — default 64 — cycles after `drp_den_o` before a DRP access is aborted (only with the timeout macro)

Ports (one clock `clk_78MHz_i`; reset `reset_i` is synchronous and active-high):
- `clk_78MHz_i` in 1 — system/DRP clock
- `reset_i` in 1 — synchronous, active-high reset
- `drp_daddr_o` out 7 — DRP address
- `drp_den_o` out 1 — DRP enable, one-cycle pulse
- `drp_dwe_o` out 1 — DRP write enable, valid with `drp_den_o`
- `drp_di_o` out 16 — DRP write data
- `drp_do_i` in 16 — DRP read data
- `drp_drdy_i` in 1 — DRP access complete
- `xadc_eoc_i` in 1 — end-of-conversion pulse
- `xadc_channel_i` in 5 — channel of the finished conversion
- `host_req_i` in 1 — host access request (level, held until ack)
- `host_we_i` in 1 — 1 = write, 0 = read
- `host_addr_i` in 7 — host DRP address
- `host_wdata_i` in 16 — host write data
- `host_ack_o` out 1 — one-cycle completion pulse
- `host_rdata_o` out 16 — read data, valid with `host_ack_o`
- `data_o` out 12 — sample, equal to `drp_do_i[15:4]`
- `channel_o` out 5 — channel of `data_o`
- `ready_o` out 1 — one-cycle sample valid
- `cfg_done_o` out 1 — configuration sequence finished
- `overrun_o` out 1 — sticky flag: an eoc arrived while one was still pending
- `err_o` out 1 — sticky flag: a DRP access timed out (timeout build only)

## Operation
- FSM states:
  - `CFG_ISSUE` and `CFG_WAIT` loop for index 0..2, writing addresses 0x40+idx.
  - Then `IDLE`.
  - From `IDLE`: `SMP_ISSUE`→`SMP_WAIT`, or `HOST_ISSUE`→`HOST_WAIT`.
  - Each `*_WAIT` state returns to `IDLE`, or to the next `CFG_ISSUE`, on `drp_drdy_i`.
- Eoc latch:
  - `xadc_eoc_i` sets `pending` and captures `xadc_channel_i`.
  - `pending` clears when `SMP_ISSUE` is entered.
  - An eoc while `pending`=1 sets `overrun_o`; the newer channel overwrites the captured one.
  - An eoc in the same cycle `pending` clears re-sets `pending` (no loss).
- Arbitration in `IDLE`: a pending sample has priority over `host_req_i`. Host requests are not served before `cfg_done_o`=1.
- Sample read: `drp_daddr_o` = {2'b00, captured channel}, i.e. status address 0x00+channel; `drp_dwe_o`=0.
- Host access:
  - `host_addr_i`, `host_we_i` and `host_wdata_i` are sampled at `HOST_ISSUE`.
  - A write returns `host_rdata_o`=0.
- `drp_drdy_i` outside a `*_WAIT` state is ignored.
- `drp_den_o` is high for exactly one cycle per access. There is never more than one outstanding access.
- Reset, including mid-access:
  - Every output returns to 0, `pending` and all flags clear.
  - The FSM restarts at `CFG_ISSUE` index 0.
  - A late `drp_drdy_i` after reset is ignored.

## Timing
- All outputs are registered.
- eoc at cycle E with FSM in `IDLE` → `pending` is high at E+1 → `drp_den_o` is high at E+2.
- `drp_drdy_i` at cycle M → `ready_o`/`data_o`/`channel_o` (or `host_ack_o`/`host_rdata_o`) at M+1. The FSM is in `IDLE` at M+1, so the next `drp_den_o` is at M+2 at the earliest.
- `data_o` and `channel_o` hold their value until the next `ready_o`.
- `cfg_done_o` rises in the cycle after the third config `drp_drdy_i` and stays high until reset.
- First config `drp_den_o` is in the second cycle after `reset_i` deasserts.

## Configuration
- Macro `XADC_DRP_TIMEOUT_EN`.
- Defined:
  - A counter starts at `drp_den_o`.
  - If `drp_drdy_i` is not seen within `TIMEOUT_CYCLES` cycles, the access is aborted and `err_o` is set.
  - Sample read: no `ready_o`.
  - Host access: `host_ack_o` with `host_rdata_o`=16'hFFFF.
  - Config write: proceeds to the next index.
- Undefined: `*_WAIT` waits indefinitely and `err_o` is tied to 0.

## Test plan
- Reset release, DRP model answers with drdy 3 cycles after each den → three writes to 0x40/0x41/0x42 with CFG0..CFG2; `cfg_done_o`=1 one cycle after the third drdy.
- eoc with channel=6, `drp_do_i`=16'hABC0 → den at eoc+2 with daddr=0x06; `ready_o` pulse, `data_o`=12'hABC, `channel_o`=6.
- Host read of 0x41 and eoc in the same idle cycle → sample read issued first, then host read; `host_ack_o` with `host_rdata_o`=model value.
- Two eocs (ch 3 then ch 4) while a read is outstanding → `overrun_o`=1; next sample read uses address 0x04.
- `XADC_DRP_TIMEOUT_EN`, model never drives drdy on a sample read → `err_o`=1 at den+`TIMEOUT_CYCLES`, no `ready_o`; a subsequent host read completes normally.
- `reset_i` asserted during `SMP_WAIT`, model drives drdy afterwards → all outputs 0, no `ready_o`, config sequence restarts at 0x40.
